// File: rtl/pio_edge_debounce.sv
// Avalon-MM input PIO for buttons/switches: per-bit 2-flop synchroniser,
// debounce, rise/fall edge select, W1C edge capture and level IRQ.

// One input channel: synchroniser plus debouncer.
module pio_deb_lane #(
  parameter int   CYCLES = 50000,
  parameter logic RST    = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic raw,
  output logic deb
);
  logic s1, s2;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= RST;
      s2 <= RST;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  assign raw = s2;

  if (CYCLES == 0) begin : g_bypass
    // Bypass: the second sync flop already is the accepted level, which
    // keeps pin-step to edge-capture latency at three cycles.
    assign deb = s2;
  end else begin : g_debounce
    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);
    logic [CW-1:0] cnt;
    logic          deb_q;

    // Accept a new level only after CYCLES consecutive cycles of
    // disagreement; any return to the held level restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt   <= '0;
        deb_q <= RST;
      end else if (s2 == deb_q) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt   <= '0;
        deb_q <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign deb = deb_q;
  end
endmodule

module pio_edge_debounce #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  logic [WIDTH-1:0] raw, deb, deb_d;
  logic [WIDTH-1:0] irq_mask, edge_capture, rise_en, fall_en;
  logic [WIDTH-1:0] wdat, clr, rise, fall;
  logic [31:0]      rd_next;
  logic             write;
  logic             unused_wd;

  assign write     = chipselect & ~write_n;
  assign wdat      = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    pio_deb_lane #(
      .CYCLES(DEBOUNCE_CYCLES),
      .RST   (RESET_LEVEL[i])
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[i]),
      .raw    (raw[i]),
      .deb    (deb[i])
    );
  end

  assign rise = deb & ~deb_d & rise_en;
  assign fall = ~deb & deb_d & fall_en;
  assign clr  = (write && address == 3'd3) ? wdat : '0;

  // Control registers written from the bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
      rise_en  <= '1;
      fall_en  <= '0;
    end else if (write) begin
      case (address)
        3'd2:    irq_mask <= wdat;
        3'd4:    rise_en  <= wdat;
        3'd5:    fall_en  <= wdat;
        default: ;
      endcase
    end
  end

  // Edge history and sticky capture; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_d        <= RESET_LEVEL;
      edge_capture <= '0;
    end else begin
      deb_d        <= deb;
      edge_capture <= (edge_capture & ~clr) | rise | fall;
    end
  end

  // Read mux, not gated by chipselect.
  always_comb begin
    rd_next = '0;
    case (address)
      3'd0:    rd_next = 32'(deb);
      3'd1:    rd_next = 32'(raw);
      3'd2:    rd_next = 32'(irq_mask);
      3'd3:    rd_next = 32'(edge_capture);
      3'd4:    rd_next = 32'(rise_en);
      3'd5:    rd_next = 32'(fall_en);
      default: rd_next = '0;
    endcase
  end

  // Registered read data, valid one cycle after address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign irq = |(edge_capture & irq_mask);
endmodule

// File: tb/tb_pio_edge_debounce.sv
// Directed bench: debounced DUT (4 cycles, keys idle high) plus a bypass
// build (0 cycles, idle low) sharing the bus.
module tb_pio_edge_debounce;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata, readdata_b;
  logic [3:0]  in_port = 4'hF;
  logic [3:0]  in_port_b = 4'h0;
  logic        irq, irq_b;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  pio_edge_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(4), .RESET_LEVEL(4'hF)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq));

  pio_edge_debounce #(.WIDTH(4), .DEBOUNCE_CYCLES(0), .RESET_LEVEL(4'h0)) u_byp (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata_b),
    .in_port(in_port_b), .irq(irq_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    address = a;
    @(posedge clk); #1;
    d = readdata;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] rd;
  logic [3:0]  exp_rst [6] = '{4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h0};
  int          deb_changes;
  logic        prev;

  initial begin
    cycles(3);
    reset_n = 1'b1;
    cycles(2);

    // 1: reset values
    for (int a = 0; a < 6; a++) begin
      bus_read(3'(a), rd);
      chk($sformatf("reset_addr%0d", a), rd, 32'(exp_rst[a]));
    end
    chk("reset_irq", 32'(irq), 32'd0);

    // 2: press bit0; level accepted on the 6th edge, no capture (rise only)
    in_port = 4'hE;
    cycles(5);
    chk("deb_before_6", 32'(dut.deb), 32'hF);
    cycles(1);
    chk("deb_at_6", 32'(dut.deb), 32'hE);
    bus_read(3'd0, rd); chk("data_pressed", rd, 32'hE);
    bus_read(3'd3, rd); chk("cap_no_fall", rd, 32'h0);
    in_port = 4'hF;
    cycles(8);
    bus_read(3'd3, rd); chk("cap_release", rd, 32'h1);

    // 3: bouncing bit1 with falling capture enabled
    bus_write(3'd5, 32'h2);
    deb_changes = 0;
    prev = dut.deb[1];
    for (int i = 0; i < 20; i++) begin
      in_port[1] = ((i / 2) % 2) == 1;
      cycles(1);
      if (dut.deb[1] !== prev) deb_changes++;
      prev = dut.deb[1];
    end
    in_port[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cycles(1);
      if (dut.deb[1] !== prev) deb_changes++;
      prev = dut.deb[1];
    end
    chk("bounce_changes", 32'(deb_changes), 32'd1);
    bus_read(3'd0, rd); chk("bounce_data", rd, 32'hD);
    bus_read(3'd3, rd); chk("bounce_cap", rd, 32'h3);

    // 4: irq masking and W1C
    bus_write(3'd2, 32'h3);
    chk("irq_set", 32'(irq), 32'd1);
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, rd); chk("w1c_bit0", rd, 32'h2);
    chk("irq_still", 32'(irq), 32'd1);
    bus_write(3'd3, 32'h2);
    chk("irq_clear", 32'(irq), 32'd0);

    // 5: clear of bit0 lands on the same edge as its new rising capture
    in_port = 4'hC;
    cycles(10);
    in_port = 4'hD;
    cycles(6);
    bus_write(3'd3, 32'h1);
    bus_read(3'd3, rd); chk("set_beats_clear", rd, 32'h1);
    chk("irq_after_race", 32'(irq), 32'd1);

    // 6: reset mid-count, then stable inputs produce no edge
    in_port = 4'h9;
    cycles(4);
    chk("cnt_mid", 32'(dut.g_lane[2].u_lane.g_debounce.cnt), 32'd2);
    reset_n = 1'b0;
    in_port = 4'hF;
    cycles(1);
    reset_n = 1'b1;
    bus_read(3'd0, rd); chk("rst_data", rd, 32'hF);
    bus_read(3'd3, rd); chk("rst_cap", rd, 32'h0);
    cycles(10);
    bus_read(3'd3, rd); chk("rst_no_edge", rd, 32'h0);

    // bypass build: capture three edges after the pin step
    in_port_b = 4'h1;
    cycles(2);
    chk("byp_cap_2", 32'(u_byp.edge_capture), 32'h0);
    cycles(1);
    chk("byp_cap_3", 32'(u_byp.edge_capture), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
